ks_sum: RTL and testbench
=========================

Name: ks_sum

Overview:
- Final stage of the 32-bit Kogge-Stone adder pipeline; sits directly downstream of the last prefix stage.
- Consumes that stage's carry-in, saved bitwise propagate and full group-generate (carry) vectors.
- Forms the sum, carry-out and status flags, and registers them behind a valid/ready handshake with a 2-entry skid buffer.
- The adder can therefore stall on downstream backpressure without losing results.

Parameters:
- WIDTH, 32, operand/sum width; must match the prefix-stage vector width.

Ports:
- i_clk  input  1  clock, rising edge
- i_rst_n  input  1  reset, synchronous, active-low
- i_valid  input  1  upstream presents a prefix result this cycle
- o_ready  output  1  this block can accept a result this cycle
- i_c0  input  1  adder carry-in
- i_pk  input  WIDTH  saved bitwise propagate, a^b
- i_gk  input  WIDTH  group generate; bit k = carry out of bit k, carry-in already folded in
- o_valid  output  1  result available
- i_ready  input  1  downstream accepts the result this cycle
- o_sum  output  WIDTH  a+b+c0, low WIDTH bits
- o_cout  output  1  carry out of the MSB
- o_ovf  output  1  signed overflow
- o_zero  output  1  o_sum == 0

Behaviour:
- Sum arithmetic, combinational on inputs before capture:
  - sum[0] = pk[0] ^ c0
  - sum[k] = pk[k] ^ gk[k-1] for 1 <= k < WIDTH
  - cout = gk[WIDTH-1]
  - ovf = gk[WIDTH-1] ^ gk[WIDTH-2]
  - zero = ~|sum
- Stored entry is {sum, cout, ovf, zero}, WIDTH+3 bits.
- Handshake:
  - Accept when i_valid & o_ready.
  - Deliver when o_valid & i_ready.
  - o_ready is a registered signal that depends only on occupancy (no combinational path from i_ready).
- Storage: output register (main) plus one skid register. Occupancy states:
  - EMPTY: o_valid=0, o_ready=1. Accept -> load main, go to ONE.
  - ONE: o_valid=1, o_ready=1.
    - Accept and deliver -> load main with new result, stay ONE.
    - Accept only -> load skid, go FULL.
    - Deliver only -> go EMPTY.
    - Neither -> hold.
  - FULL: o_valid=1, o_ready=0; input ignored.
    - Deliver -> main takes skid, go ONE.
    - Otherwise hold.
- Latency: 1 cycle from accept in EMPTY (or ONE with simultaneous delivery) to o_valid with that result.
- Throughput: 1 result/cycle while i_ready=1.
- Ordering: strict FIFO; no drop, no duplication.
- While o_valid=1 and i_ready=0, all outputs are held stable.
- i_valid while o_ready=0 is ignored; upstream holds it.
- Reset (i_rst_n=0 at a rising edge):
  - State goes EMPTY; o_valid=0, o_ready=1.
  - o_sum=0, o_cout=0, o_ovf=0, o_zero=0; skid contents cleared.
  - Reset mid-operation discards both buffered entries; it takes priority over simultaneous accept/deliver.
- o_ready is 1 in the first cycle after reset deasserts.
- o_sum/o_cout/o_ovf/o_zero are only meaningful while o_valid=1.

Decomposition:
- Shared package ks_pkg: KS_WIDTH=32; stored-entry field offsets (SUM, COUT, OVF, ZERO); entry-width constant KS_ENTRY_W = KS_WIDTH+3.
- Sub-module ks_skid: generic 2-entry valid/ready skid buffer, parameterised on entry width; owns the EMPTY/ONE/FULL state.
- ks_sum: the sum/flag logic plus one ks_skid instance.

Test Plan:
- a=0xFFFFFFFF, b=1, c0=0 (pk=0xFFFFFFFE, gk=0xFFFFFFFF), i_ready=1 -> next cycle o_valid=1, o_sum=0, o_cout=1, o_zero=1, o_ovf=0.
- a=0x7FFFFFFF, b=1, c0=0 (pk=0x7FFFFFFE, gk=0x7FFFFFFF) -> o_sum=0x80000000, o_ovf=1, o_cout=0, o_zero=0.
- pk=0, gk=0, c0=1 -> o_sum=0x00000001, flags 0; then pk=0x0000000F, gk=0, c0=0 -> o_sum=0x0000000F.
- Hold i_ready=0 and present results R1, R2, R3 back-to-back:
  - R1 in main, R2 in skid; o_ready=0 from the cycle after R2 is accepted; R3 held upstream.
  - Release i_ready -> R1, R2, R3 delivered in order, none lost.
- Streaming 100 random operands with i_ready=1 -> 1 result/cycle, each matching a+b+c0 against a reference model.
- Assert i_rst_n=0 while FULL with i_valid=1 and i_ready=1 -> next cycle o_valid=0, o_ready=1, o_sum=0; no stale result appears after reset release.

Source files
------------

// File: rtl/ks_pkg.sv
// Shared constants for the Kogge-Stone final stage: operand width, the
// layout of a stored result entry {sum, cout, ovf, zero}, and the skid
// buffer occupancy encoding.
package ks_pkg;

  localparam int KS_WIDTH   = 32;
  localparam int KS_ENTRY_W = KS_WIDTH + 3;

  // Bit offsets inside a stored entry (zero flag is the LSB).
  localparam int KS_OFF_ZERO = 0;
  localparam int KS_OFF_OVF  = 1;
  localparam int KS_OFF_COUT = 2;
  localparam int KS_OFF_SUM  = 3;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/ks_sum_if.sv
// Handshake + data bundle between the last prefix stage, ks_sum and its
// consumer. slave = ks_sum's view, master = the environment driving it.
// Signals: i_valid/o_ready/i_c0/i_pk/i_gk upstream, o_valid/i_ready and
// o_sum/o_cout/o_ovf/o_zero downstream.
interface ks_sum_if
  import ks_pkg::*;
#(
  parameter int WIDTH = KS_WIDTH
);

  logic             i_valid;
  logic             o_ready;
  logic             i_c0;
  logic [WIDTH-1:0] i_pk;
  logic [WIDTH-1:0] i_gk;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_sum;
  logic             o_cout;
  logic             o_ovf;
  logic             o_zero;

  modport slave (
    input  i_valid, i_c0, i_pk, i_gk, i_ready,
    output o_ready, o_valid, o_sum, o_cout, o_ovf, o_zero
  );

  modport master (
    output i_valid, i_c0, i_pk, i_gk, i_ready,
    input  o_ready, o_valid, o_sum, o_cout, o_ovf, o_zero
  );

endinterface

// File: rtl/ks_skid.sv
// Generic 2-entry valid/ready skid buffer (main output register + skid).
// Latency: 1 cycle from accept to o_valid when main is free or draining.
// Backpressure: o_ready decodes registered occupancy only; drops when FULL.
// Ports: i_clk, i_rst_n (sync, active-low), i_valid/o_ready/i_dat upstream,
// o_valid/i_ready/o_dat downstream.
module ks_skid
  import ks_pkg::*;
#(
  parameter int W = KS_ENTRY_W
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_dat,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_dat
);

  skid_state_e  state_q, state_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         acc;
  logic         dlv;

  // Both handshake outputs are pure decodes of the state register, so
  // i_ready never reaches o_ready combinationally.
  assign o_valid = (state_q != SKID_EMPTY);
  assign o_ready = (state_q != SKID_FULL);
  assign o_dat   = main_q;

  assign acc = i_valid & o_ready;
  assign dlv = o_valid & i_ready;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= SKID_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      SKID_EMPTY: begin
        if (acc) begin
          main_d  = i_dat;
          state_d = SKID_ONE;
        end
      end
      SKID_ONE: begin
        if (acc && dlv) begin
          main_d = i_dat;
        end else if (acc) begin
          // main is stalled: park the newcomer behind it
          skid_d  = i_dat;
          state_d = SKID_FULL;
        end else if (dlv) begin
          state_d = SKID_EMPTY;
        end
      end
      SKID_FULL: begin
        if (dlv) begin
          main_d  = skid_q;
          state_d = SKID_ONE;
        end
      end
      default: begin
        state_d = SKID_EMPTY;
      end
    endcase
  end

endmodule

// File: rtl/ks_sum.sv
// Kogge-Stone final stage: sum/cout/ovf/zero from propagate + group carries.
// Latency: 1 cycle from accept to o_valid (through ks_skid).
// Backpressure: 2-entry skid; o_ready falls only when both entries are held.
// Ports: i_clk, i_rst_n (sync, active-low), bus (ks_sum_if.slave) carrying
// the prefix-stage inputs, handshake and registered result/flags.
module ks_sum
  import ks_pkg::*;
#(
  parameter int WIDTH = KS_WIDTH
) (
  input  logic     i_clk,
  input  logic     i_rst_n,
  ks_sum_if.slave  bus
);

  localparam int ENTRY_W = WIDTH + (KS_ENTRY_W - KS_WIDTH);

  logic [WIDTH-1:0]   sum;
  logic               cout;
  logic               ovf;
  logic               zero;
  logic [ENTRY_W-1:0] entry_in;
  logic [ENTRY_W-1:0] entry_out;

  // Bit k sums with the carry into k: c0 for bit 0, gk[k-1] above.
  assign sum  = bus.i_pk ^ {bus.i_gk[WIDTH-2:0], bus.i_c0};
  assign cout = bus.i_gk[WIDTH-1];
  // Signed overflow: carry into MSB differs from carry out of MSB.
  assign ovf  = bus.i_gk[WIDTH-1] ^ bus.i_gk[WIDTH-2];
  assign zero = ~|sum;

  always_comb begin
    entry_in                          = '0;
    entry_in[KS_OFF_SUM +: WIDTH]     = sum;
    entry_in[KS_OFF_COUT]             = cout;
    entry_in[KS_OFF_OVF]              = ovf;
    entry_in[KS_OFF_ZERO]             = zero;
  end

  ks_skid #(
    .W (ENTRY_W)
  ) u_skid (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (bus.i_valid),
    .o_ready (bus.o_ready),
    .i_dat   (entry_in),
    .o_valid (bus.o_valid),
    .i_ready (bus.i_ready),
    .o_dat   (entry_out)
  );

  assign bus.o_sum  = entry_out[KS_OFF_SUM +: WIDTH];
  assign bus.o_cout = entry_out[KS_OFF_COUT];
  assign bus.o_ovf  = entry_out[KS_OFF_OVF];
  assign bus.o_zero = entry_out[KS_OFF_ZERO];

endmodule

// File: tb/tb_ks_sum.sv
// Bench for ks_sum: operands a, b, c0 are turned into (pk, gk) by a plain
// arithmetic reference, and results are predicted directly from a+b+c0.
module tb_ks_sum;
  import ks_pkg::*;

  typedef logic [KS_WIDTH+2:0] exp_t; // {sum, cout, ovf, zero}

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  ks_sum_if #(.WIDTH(KS_WIDTH)) bus();

  ks_sum #(.WIDTH(KS_WIDTH)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  exp_t got;
  assign got = {bus.o_sum, bus.o_cout, bus.o_ovf, bus.o_zero};

  // Expected result straight from integer addition.
  function automatic exp_t ref_add(input logic [31:0] a, input logic [31:0] b, input logic c0);
    logic [32:0] full;
    logic [31:0] s;
    logic        ov;
    full = {1'b0, a} + {1'b0, b} + {32'd0, c0};
    s    = full[31:0];
    ov   = (a[31] == b[31]) && (s[31] != a[31]);
    return {s, full[32], ov, (s == 32'd0)};
  endfunction

  // gk[k] = carry out of bit k of a+b+c0, from partial-width sums.
  function automatic logic [31:0] ref_gk(input logic [31:0] a, input logic [31:0] b, input logic c0);
    logic [32:0] m;
    logic [32:0] part;
    logic [31:0] g;
    g = '0;
    for (int k = 0; k < 32; k++) begin
      m    = (33'd1 << (k + 1)) - 33'd1;
      part = ({1'b0, a} & m) + ({1'b0, b} & m) + {32'd0, c0};
      g[k] = part[k+1];
    end
    return g;
  endfunction

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic c0);
    bus.i_pk = a ^ b;
    bus.i_gk = ref_gk(a, b, c0);
    bus.i_c0 = c0;
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b0;
    bus.i_pk    = '0;
    bus.i_gk    = '0;
    bus.i_c0    = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (bus.o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", bus.o_valid); end
    total++; if (bus.o_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", bus.o_ready); end
    total++; if (got !== '0) begin bad++; $display("FAIL reset_data got=%h want=0", got); end
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (bus.o_ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready got=%b want=1", bus.o_ready); end
    total++; if (bus.o_valid !== 1'b0) begin bad++; $display("FAIL post_reset_valid got=%b want=0", bus.o_valid); end
  endtask

  task automatic test_directed();
    logic [31:0] va [4];
    logic [31:0] vb [4];
    logic        vc [4];
    exp_t        want [4];
    va[0] = 32'hFFFF_FFFF; vb[0] = 32'd1; vc[0] = 1'b0; want[0] = {32'h0000_0000, 1'b1, 1'b0, 1'b1};
    va[1] = 32'h7FFF_FFFF; vb[1] = 32'd1; vc[1] = 1'b0; want[1] = {32'h8000_0000, 1'b0, 1'b1, 1'b0};
    va[2] = 32'h0000_0000; vb[2] = 32'd0; vc[2] = 1'b1; want[2] = {32'h0000_0001, 1'b0, 1'b0, 1'b0};
    va[3] = 32'h0000_000F; vb[3] = 32'd0; vc[3] = 1'b0; want[3] = {32'h0000_000F, 1'b0, 1'b0, 1'b0};
    bus.i_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(va[i], vb[i], vc[i]);
      bus.i_valid = 1'b1;
      @(negedge clk);
      bus.i_valid = 1'b0;
      total++; if (bus.o_valid !== 1'b1) begin bad++; $display("FAIL directed%0d_valid got=%b want=1", i, bus.o_valid); end
      total++; if (got !== want[i]) begin bad++; $display("FAIL directed%0d_data got=%h want=%h", i, got, want[i]); end
    end
    @(negedge clk);
    total++; if (bus.o_valid !== 1'b0) begin bad++; $display("FAIL directed_drain got=%b want=0", bus.o_valid); end
  endtask

  task automatic test_backpressure();
    logic [31:0] a [3];
    logic [31:0] b [3];
    logic        c [3];
    exp_t        r [3];
    for (int i = 0; i < 3; i++) begin
      a[i] = $urandom; b[i] = $urandom; c[i] = 1'($urandom_range(0, 1));
      r[i] = ref_add(a[i], b[i], c[i]);
    end
    bus.i_ready = 1'b0;
    @(negedge clk);
    drive(a[0], b[0], c[0]); bus.i_valid = 1'b1;
    @(negedge clk); // R1 in main
    total++; if (bus.o_ready !== 1'b1) begin bad++; $display("FAIL bp_one_ready got=%b want=1", bus.o_ready); end
    total++; if (got !== r[0]) begin bad++; $display("FAIL bp_r1_main got=%h want=%h", got, r[0]); end
    drive(a[1], b[1], c[1]);
    @(negedge clk); // R2 in skid
    total++; if (bus.o_ready !== 1'b0) begin bad++; $display("FAIL bp_full_ready got=%b want=0", bus.o_ready); end
    total++; if (got !== r[0]) begin bad++; $display("FAIL bp_r1_held got=%h want=%h", got, r[0]); end
    drive(a[2], b[2], c[2]);
    @(negedge clk); // R3 must be ignored
    total++; if (bus.o_ready !== 1'b0 || bus.o_valid !== 1'b1) begin bad++; $display("FAIL bp_full_hold got rdy=%b vld=%b want rdy=0 vld=1", bus.o_ready, bus.o_valid); end
    total++; if (got !== r[0]) begin bad++; $display("FAIL bp_r1_stable got=%h want=%h", got, r[0]); end
    bus.i_ready = 1'b1;
    @(negedge clk); // R1 delivered, R2 to main
    total++; if (got !== r[1] || bus.o_valid !== 1'b1) begin bad++; $display("FAIL bp_r2_out got=%h want=%h", got, r[1]); end
    total++; if (bus.o_ready !== 1'b1) begin bad++; $display("FAIL bp_drain_ready got=%b want=1", bus.o_ready); end
    @(negedge clk); // R3 accepted while R2 delivered
    bus.i_valid = 1'b0;
    total++; if (got !== r[2] || bus.o_valid !== 1'b1) begin bad++; $display("FAIL bp_r3_out got=%h want=%h", got, r[2]); end
    @(negedge clk);
    total++; if (bus.o_valid !== 1'b0) begin bad++; $display("FAIL bp_empty got=%b want=0", bus.o_valid); end
  endtask

  task automatic test_stream();
    exp_t        q [$];
    exp_t        e;
    logic [31:0] a, b;
    logic        c;
    bus.i_ready = 1'b1;
    for (int i = 0; i <= 100; i++) begin
      @(negedge clk);
      if (i > 0) begin
        e = q.pop_front();
        total++; if (bus.o_valid !== 1'b1) begin bad++; $display("FAIL stream%0d_valid got=%b want=1", i, bus.o_valid); end
        total++; if (got !== e) begin bad++; $display("FAIL stream%0d_data got=%h want=%h", i, got, e); end
      end
      total++; if (bus.o_ready !== 1'b1) begin bad++; $display("FAIL stream%0d_ready got=%b want=1", i, bus.o_ready); end
      if (i < 100) begin
        a = $urandom; b = $urandom; c = 1'($urandom_range(0, 1));
        drive(a, b, c);
        bus.i_valid = 1'b1;
        q.push_back(ref_add(a, b, c));
      end else begin
        bus.i_valid = 1'b0;
      end
    end
    @(negedge clk);
    total++; if (bus.o_valid !== 1'b0) begin bad++; $display("FAIL stream_end got=%b want=0", bus.o_valid); end
  endtask

  task automatic test_random_stall();
    exp_t        q [$];
    exp_t        cur, e, prev;
    logic [31:0] a, b;
    logic        c;
    logic        acc_prev, held_prev;
    int          sent;
    sent = 0; acc_prev = 1'b0; held_prev = 1'b0; cur = '0; prev = '0;
    bus.i_valid = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      if (held_prev) begin
        total++; if (got !== prev || bus.o_valid !== 1'b1) begin bad++; $display("FAIL stall_hold cyc=%0d got=%h want=%h", cyc, got, prev); end
      end
      if (acc_prev) bus.i_valid = 1'b0;
      bus.i_ready = 1'($urandom_range(0, 1));
      if (!bus.i_valid && sent < 60 && $urandom_range(0, 2) != 0) begin
        a = $urandom; b = $urandom; c = 1'($urandom_range(0, 1));
        drive(a, b, c);
        cur = ref_add(a, b, c);
        bus.i_valid = 1'b1;
      end
      if (bus.o_valid && bus.i_ready) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL stall_spurious cyc=%0d got=%h want=none", cyc, got);
        end else begin
          e = q.pop_front();
          if (got !== e) begin bad++; $display("FAIL stall_data cyc=%0d got=%h want=%h", cyc, got, e); end
        end
      end
      acc_prev = bus.i_valid && bus.o_ready;
      if (acc_prev) begin
        q.push_back(cur);
        sent++;
      end
      held_prev = bus.o_valid && !bus.i_ready;
      prev      = got;
      if (sent == 60 && q.size() == 0 && !acc_prev) break;
    end
    bus.i_valid = 1'b0;
    total++; if (sent != 60 || q.size() != 0) begin bad++; $display("FAIL stall_complete sent=%0d left=%0d want sent=60 left=0", sent, q.size()); end
  endtask

  task automatic test_reset_full();
    bus.i_ready = 1'b0;
    @(negedge clk);
    drive($urandom, $urandom, 1'b1); bus.i_valid = 1'b1;
    @(negedge clk);
    drive($urandom, $urandom, 1'b0);
    @(negedge clk);
    total++; if (bus.o_ready !== 1'b0) begin bad++; $display("FAIL rst_full_ready got=%b want=0", bus.o_ready); end
    rst_n = 1'b0;
    drive(32'h1234_5678, 32'h1111_1111, 1'b0);
    bus.i_valid = 1'b1;
    bus.i_ready = 1'b1;
    @(negedge clk);
    total++; if (bus.o_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid got=%b want=0", bus.o_valid); end
    total++; if (bus.o_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_ready got=%b want=1", bus.o_ready); end
    total++; if (got !== '0) begin bad++; $display("FAIL rst_mid_data got=%h want=0", got); end
    rst_n = 1'b1;
    bus.i_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1) begin bad++; $display("FAIL rst_stale%0d got vld=%b rdy=%b want vld=0 rdy=1", i, bus.o_valid, bus.o_ready); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_stream();
    test_random_stall();
    test_reset_full();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
